// File: rtl/mux_nto1_pipe.sv
// N-to-1 word multiplexer with a registered two-entry (head + skid) output buffer.
// Selects one channel per accepted transfer and keeps strict FIFO order under backpressure.
module mux_nto1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [SEL_W:0]   NUM_IN_C = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_IN - 1);

    state_t            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  head_data_q;
    logic [SEL_W-1:0]  head_sel_q;
    logic              head_err_q;
    logic [WIDTH-1:0]  skid_data_q;
    logic [SEL_W-1:0]  skid_sel_q;
    logic              skid_err_q;

    logic [WIDTH-1:0]  cap_data_d;
    logic [SEL_W-1:0]  cap_sel_d;
    logic              cap_err_d;
    logic              accept_s;
    logic              pop_s;

    assign accept_s = in_valid & in_ready_q;
    assign pop_s    = out_valid_q & out_ready;

    // Resolve the effective channel (out-of-range folds onto the last channel) and pick its word
    always_comb begin
        cap_err_d  = ({1'b0, sel} >= NUM_IN_C);
        cap_data_d = {WIDTH{1'b0}};
        if (cap_err_d) begin
            cap_sel_d = LAST_CH;
        end else begin
            cap_sel_d = sel;
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (cap_sel_d == SEL_W'(k)) begin
                cap_data_d = in_data[k*WIDTH +: WIDTH];
            end else begin
                cap_data_d = cap_data_d;
            end
        end
    end

    // Occupancy state machine driving head/skid storage and the registered handshake outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_data_q <= {WIDTH{1'b0}};
            head_sel_q  <= {SEL_W{1'b0}};
            head_err_q  <= 1'b0;
            skid_data_q <= {WIDTH{1'b0}};
            skid_sel_q  <= {SEL_W{1'b0}};
            skid_err_q  <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_s) begin
                        head_data_q <= cap_data_d;
                        head_sel_q  <= cap_sel_d;
                        head_err_q  <= cap_err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end else begin
                        state_q     <= EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        head_data_q <= cap_data_d;
                        head_sel_q  <= cap_sel_d;
                        head_err_q  <= cap_err_d;
                        state_q     <= ONE;
                    end else if (accept_s) begin
                        skid_data_q <= cap_data_d;
                        skid_sel_q  <= cap_sel_d;
                        skid_err_q  <= cap_err_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= FULL;
                    end else if (pop_s) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end else begin
                        state_q     <= ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can change state
                    if (pop_s) begin
                        head_data_q <= skid_data_q;
                        head_sel_q  <= skid_sel_q;
                        head_err_q  <= skid_err_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ONE;
                    end else begin
                        state_q     <= FULL;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = head_data_q;
    assign out_sel   = head_sel_q;
    assign sel_err   = head_err_q;
    assign level     = state_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed self-checking bench: default 3x32 instance plus a 5x8 instance for the parameter sweep.
module tb_mux_nto1_pipe;

    logic        clk;
    logic        rst_n;

    // default instance
    logic [95:0] a_in_data;
    logic [1:0]  a_sel;
    logic        a_in_valid, a_in_ready, a_out_ready, a_out_valid, a_sel_err;
    logic [31:0] a_out_data;
    logic [1:0]  a_out_sel, a_level;

    // WIDTH=8, NUM_IN=5, SEL_W=3 instance
    logic [39:0] b_in_data;
    logic [2:0]  b_sel;
    logic        b_in_valid, b_in_ready, b_out_ready, b_out_valid, b_sel_err;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_sel;
    logic [1:0]  b_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  sel;
        logic        vld;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  es;
        logic        ee;
        logic [1:0]  el;
        logic        er;
    } vec_t;

    vec_t stream_tbl[5];
    vec_t sweep_tbl[5];

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_a (
        .Clk(clk), .Reset(rst_n), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_sel(a_out_sel), .sel_err(a_sel_err), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .level(a_level)
    );

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) dut_b (
        .Clk(clk), .Reset(rst_n), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_sel(b_out_sel), .sel_err(b_sel_err), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .level(b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic ev, input logic [31:0] ed,
                         input logic [1:0] es, input logic ee, input logic [1:0] el, input logic er);
        chk({tag, ".out_valid"}, {31'd0, a_out_valid}, {31'd0, ev});
        chk({tag, ".out_data"},  a_out_data, ed);
        chk({tag, ".out_sel"},   {30'd0, a_out_sel}, {30'd0, es});
        chk({tag, ".sel_err"},   {31'd0, a_sel_err}, {31'd0, ee});
        chk({tag, ".level"},     {30'd0, a_level}, {30'd0, el});
        chk({tag, ".in_ready"},  {31'd0, a_in_ready}, {31'd0, er});
    endtask

    initial begin
        // inputs held idle until used
        rst_n       = 1'b1;
        a_in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
        a_sel       = 2'd1;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b0;
        b_in_data   = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_sel       = 3'd0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;

        stream_tbl[0] = '{4'd0, 1'b1, 1'b1, 1'b1, 32'h11111111, 4'd0, 1'b0, 2'd1, 1'b1};
        stream_tbl[1] = '{4'd1, 1'b1, 1'b1, 1'b1, 32'h22222222, 4'd1, 1'b0, 2'd1, 1'b1};
        stream_tbl[2] = '{4'd2, 1'b1, 1'b1, 1'b1, 32'h33333333, 4'd2, 1'b0, 2'd1, 1'b1};
        stream_tbl[3] = '{4'd3, 1'b1, 1'b1, 1'b1, 32'h33333333, 4'd2, 1'b1, 2'd1, 1'b1};
        stream_tbl[4] = '{4'd0, 1'b0, 1'b1, 1'b0, 32'h33333333, 4'd2, 1'b1, 2'd0, 1'b1};

        sweep_tbl[0]  = '{4'd4, 1'b1, 1'b1, 1'b1, 32'h000000A4, 4'd4, 1'b0, 2'd1, 1'b1};
        sweep_tbl[1]  = '{4'd5, 1'b1, 1'b1, 1'b1, 32'h000000A4, 4'd4, 1'b1, 2'd1, 1'b1};
        sweep_tbl[2]  = '{4'd6, 1'b1, 1'b1, 1'b1, 32'h000000A4, 4'd4, 1'b1, 2'd1, 1'b1};
        sweep_tbl[3]  = '{4'd7, 1'b1, 1'b1, 1'b1, 32'h000000A4, 4'd4, 1'b1, 2'd1, 1'b1};
        sweep_tbl[4]  = '{4'd2, 1'b0, 1'b1, 1'b0, 32'h000000A4, 4'd4, 1'b1, 2'd0, 1'b1};

        // reset for two cycles with a transfer offered
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        chk_a("reset", 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        chk("reset.b_level", {30'd0, b_level}, 32'd0);
        a_in_valid = 1'b0;
        rst_n      = 1'b1;
        tick();
        chk_a("post_reset", 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);

        // streaming and out-of-range select
        for (int i = 0; i < 5; i++) begin
            a_sel       = stream_tbl[i].sel[1:0];
            a_in_valid  = stream_tbl[i].vld;
            a_out_ready = stream_tbl[i].ordy;
            tick();
            chk_a($sformatf("stream[%0d]", i), stream_tbl[i].ev, stream_tbl[i].ed,
                  stream_tbl[i].es[1:0], stream_tbl[i].ee, stream_tbl[i].el, stream_tbl[i].er);
        end

        // backpressure: A and B accepted, C refused until space frees up
        a_sel       = 2'd0;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data[31:0] = 32'h0000000A;
        tick();
        chk_a("bp.A", 1'b1, 32'h0000000A, 2'd0, 1'b0, 2'd1, 1'b1);
        a_in_data[31:0] = 32'h0000000B;
        tick();
        chk_a("bp.B", 1'b1, 32'h0000000A, 2'd0, 1'b0, 2'd2, 1'b0);
        a_in_data[31:0] = 32'h0000000C;
        tick();
        chk_a("bp.C_held", 1'b1, 32'h0000000A, 2'd0, 1'b0, 2'd2, 1'b0);
        a_out_ready = 1'b1;
        tick();
        chk_a("bp.pop_A", 1'b1, 32'h0000000B, 2'd0, 1'b0, 2'd1, 1'b1);
        tick();
        chk_a("bp.pop_B", 1'b1, 32'h0000000C, 2'd0, 1'b0, 2'd1, 1'b1);
        a_in_valid = 1'b0;
        tick();
        chk_a("bp.pop_C", 1'b0, 32'h0000000C, 2'd0, 1'b0, 2'd0, 1'b1);

        // fill to FULL, then reset discards both entries
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data[31:0] = 32'h0000000A;
        tick();
        a_in_data[31:0] = 32'h0000000B;
        tick();
        chk_a("full", 1'b1, 32'h0000000A, 2'd0, 1'b0, 2'd2, 1'b0);
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        tick();
        chk_a("rst_full", 1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_full.no_out[%0d]", i), {31'd0, a_out_valid}, 32'd0);
        end

        // parameter sweep on the 5-channel, 8-bit instance
        for (int i = 0; i < 5; i++) begin
            b_sel       = sweep_tbl[i].sel[2:0];
            b_in_valid  = sweep_tbl[i].vld;
            b_out_ready = sweep_tbl[i].ordy;
            tick();
            chk($sformatf("sweep[%0d].out_valid", i), {31'd0, b_out_valid}, {31'd0, sweep_tbl[i].ev});
            chk($sformatf("sweep[%0d].out_data", i), {24'd0, b_out_data}, sweep_tbl[i].ed);
            chk($sformatf("sweep[%0d].out_sel", i), {29'd0, b_out_sel}, {28'd0, sweep_tbl[i].es});
            chk($sformatf("sweep[%0d].sel_err", i), {31'd0, b_sel_err}, {31'd0, sweep_tbl[i].ee});
            chk($sformatf("sweep[%0d].level", i), {30'd0, b_level}, {30'd0, sweep_tbl[i].el});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 word multiplexer with a registered, flow-controlled output stage. It is the pipelined successor to the datapath's fixed-width 3-to-1 selector. It sits between a pipeline stage's candidate sources (register-file read, EX/MEM result, MEM/WB result, immediate, ...) and the consuming stage. It selects one channel per accepted transfer and buffers up to two results under backpressure, without loss or duplication.

## Interface
- WIDTH, 32, data word width in bits
- NUM_IN, 3, number of input channels (legal range 2..2^SEL_W)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN

- Clk  input  1  rising-edge clock; only clock
- Reset  input  1  synchronous, active-low reset (sampled on Clk rising edge while low)
- in_data  input  NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  requested channel, qualified by in_valid
- in_valid  input  1  producer has a transfer this cycle
- in_ready  output  1  block can accept this cycle; registered
- out_data  output  WIDTH  selected word at head of buffer
- out_sel  output  SEL_W  channel actually selected for out_data
- sel_err  output  1  head transfer used an out-of-range sel
- out_valid  output  1  out_data/out_sel/sel_err are valid
- out_ready  input  1  consumer takes head this cycle
- level  output  2  buffer occupancy, 0..2

## Operation
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Effective channel e = (sel < NUM_IN) ? sel : NUM_IN-1. Out-of-range sel selects the last channel, as in the existing selector. The captured err bit = (sel >= NUM_IN).
- Each accepted transfer captures {in_data[e], e, err} into a 2-entry buffer (head register plus skid register). No data is stored unselected.
- State machine on level:
  - EMPTY (0): Accept loads head and moves to ONE.
  - ONE (1):
    - Accept & Pop: head is replaced by the new transfer; stays in ONE.
    - Accept & !Pop: skid is loaded; moves to FULL.
    - !Accept & Pop: moves to EMPTY.
    - Otherwise: holds.
  - FULL (2): in_ready = 0, so no Accept is possible. Pop moves skid to head and goes to ONE.
- in_ready = (next level != 2), registered. It is low exactly while level == 2.
- Ordering is strict FIFO. Every accepted word appears on the output exactly once.
- With out_valid = 0, out_data, out_sel and sel_err hold their last values; consumers must ignore them.
- The design is purely synchronous. No combinational path exists from in_* to out_*, or from out_ready to in_ready.

## Timing
- Reset values (the edge after Reset is sampled low): out_valid=0, out_data=0, out_sel=0, sel_err=0, level=0, in_ready=1. Transfers presented in a reset cycle are dropped.
- Reset mid-operation discards both buffer entries. Discarded contents never reach the output.
- Latency: an accept at edge n gives out_valid=1 with that word after edge n (1 cycle).
- Throughput: 1 word per cycle when out_ready is held high.
- Backpressure: with out_ready=0, two words are accepted and in_ready falls after the second. On the first Pop, in_ready returns high in the following cycle.
- Simultaneous Accept and Pop in ONE: the popped word leaves, the new word becomes head, and level stays 1.

## Test plan
- Reset: hold Reset=0 for 2 cycles with in_valid=1, sel=1 -> out_valid=0, out_data=0, level=0, in_ready=1. No word appears after release.
- Streaming: out_ready=1 with ch0=0x11111111, ch1=0x22222222, ch2=0x33333333, in_valid=1 and sel=0,1,2 on consecutive cycles -> out_data 0x11111111, 0x22222222, 0x33333333 on consecutive cycles starting 1 cycle later, out_sel=0,1,2, sel_err=0.
- Out-of-range: sel=3 with ch2=0x33333333 -> out_data=0x33333333, out_sel=2, sel_err=1.
- Backpressure: out_ready=0, offer A=0xA, B=0xB, C=0xC -> level goes 1 then 2, in_ready=0, and C is not accepted. Raise out_ready -> outputs A, B, C in order, none lost or duplicated.
- Reset while FULL -> next edge level=0, out_valid=0, in_ready=1. A and B never appear.
- Parameter sweep: WIDTH=8, NUM_IN=5, SEL_W=3 -> sel=4 gives ch4 with sel_err=0; sel=5, 6, 7 give ch4 with sel_err=1.
